// File: rtl/game_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : game_pkg
// Purpose  : Shared game state codes for the controller, renderer and
//            character blocks, plus a small saturating-decrement helper.
// Ports    : (package, no ports)
// Revision : 1.0  initial release
// ============================================================================
package game_pkg;

  typedef enum logic [2:0] {
    ST_MENU  = 3'b000,
    ST_PLAY  = 3'b001,
    ST_LOSE  = 3'b010,
    ST_WIN   = 3'b011,
    ST_DYING = 3'b100
  } game_state_e;

  // Lives never wrap from 0 back to 3.
  function automatic logic [1:0] lives_dec_sat(input logic [1:0] cur);
    return (cur == 2'd0) ? 2'd0 : cur - 2'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/key_debounce.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : key_debounce
// Purpose  : Two-flop synchroniser, counter debounce and falling-edge detect
//            for an active-low mechanical key.
// Ports    : clk    - system clock
//            rst    - synchronous active-high reset
//            key_n  - raw asynchronous active-low key
//            level  - debounced key level (idle high)
//            press  - one-cycle pulse on debounced 1->0 transition
// Revision : 1.0  initial release
// ============================================================================
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst,
  input  logic key_n,
  output logic level,
  output logic press
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic [CW-1:0] cnt;

  // Synchroniser flops reset to the idle (released) level so that leaving
  // reset can never look like a key press.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      level <= 1'b1;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      sync1 <= key_n;
      sync2 <= sync1;
      press <= 1'b0;
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        // N-th consecutive differing sample: accept the new level. The old
        // level being high means this is the falling (press) edge.
        level <= sync2;
        cnt   <= '0;
        press <= level;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/game_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : game_ctrl
// Purpose  : Game flow controller: menu, play with round timer, dying
//            animation with lives, win and lose screens.
// Ports    : clk, rst          - clock, synchronous active-high reset
//            start_n           - raw active-low start key
//            frame_tick        - one-cycle pulse per video frame
//            in_lava, at_goal  - character status levels
//            force_lose/win    - debug switch levels
//            state             - game state code (game_pkg encoding)
//            lives, time_left  - remaining lives / seconds
//            respawn           - one-cycle pulse: return character to spawn
// Revision : 1.0  initial release
// ============================================================================
module game_ctrl
  import game_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int START_LIVES     = 3,
  parameter int TIME_LIMIT_S    = 60,
  parameter int FRAMES_PER_SEC  = 60,
  parameter int DEATH_FRAMES    = 30
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_n,
  input  logic       frame_tick,
  input  logic       in_lava,
  input  logic       at_goal,
  input  logic       force_lose,
  input  logic       force_win,
  output logic [2:0] state,
  output logic [1:0] lives,
  output logic [6:0] time_left,
  output logic       respawn
);

  localparam int FW = (FRAMES_PER_SEC > 1) ? $clog2(FRAMES_PER_SEC) : 1;
  localparam int DW = (DEATH_FRAMES > 1) ? $clog2(DEATH_FRAMES) : 1;
  localparam logic [FW-1:0] FRAME_LAST = FW'(FRAMES_PER_SEC - 1);
  localparam logic [DW-1:0] DEATH_LAST = DW'(DEATH_FRAMES - 1);
  localparam logic [1:0]    LIVES_INIT = 2'(START_LIVES);
  localparam logic [6:0]    TIME_INIT  = 7'(TIME_LIMIT_S);

  game_state_e   cur_state;
  game_state_e   nxt_state;
  logic          start_press;
  logic          start_level;
  logic [FW-1:0] frame_cnt;
  logic [FW-1:0] frame_nxt;
  logic [DW-1:0] death_cnt;
  logic [DW-1:0] death_nxt;
  logic [1:0]    lives_nxt;
  logic [6:0]    time_nxt;
  logic          respawn_nxt;
  logic          sec_done;
  logic          time_expire;
  logic          death_done;

  key_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_key (
    .clk  (clk),
    .rst  (rst),
    .key_n(start_n),
    .level(start_level),
    .press(start_press)
  );

  // A second elapses on the last frame of the second; the round is lost when
  // that decrement lands on zero.
  assign sec_done    = frame_tick && (frame_cnt == FRAME_LAST);
  assign time_expire = sec_done && (time_left <= 7'd1);
  assign death_done  = frame_tick && (death_cnt == DEATH_LAST);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      cur_state <= ST_MENU;
    end else begin
      cur_state <= nxt_state;
    end
  end

  // Next-state logic
  always_comb begin
    nxt_state = cur_state;
    case (cur_state)
      ST_MENU:  if (start_press) nxt_state = ST_PLAY;
      ST_PLAY: begin
        if (force_lose || time_expire)  nxt_state = ST_LOSE;
        else if (in_lava)               nxt_state = ST_DYING;
        else if (at_goal || force_win)  nxt_state = ST_WIN;
      end
      ST_DYING: begin
        // lives already holds the post-death value here
        if (death_done) nxt_state = (lives == 2'd0) ? ST_LOSE : ST_PLAY;
      end
      ST_LOSE:  if (start_press) nxt_state = ST_PLAY;
      ST_WIN:   if (start_press) nxt_state = ST_MENU;
      default:  nxt_state = ST_MENU;
    endcase
  end

  // Output / datapath next values
  always_comb begin
    lives_nxt   = lives;
    time_nxt    = time_left;
    frame_nxt   = frame_cnt;
    death_nxt   = death_cnt;
    respawn_nxt = 1'b0;
    case (cur_state)
      ST_MENU, ST_LOSE: begin
        if (start_press) begin
          lives_nxt   = LIVES_INIT;
          time_nxt    = TIME_INIT;
          frame_nxt   = '0;
          respawn_nxt = 1'b1;
        end
      end
      ST_PLAY: begin
        // The timer keeps running on the exit cycle too.
        if (frame_tick) begin
          frame_nxt = sec_done ? '0 : frame_cnt + 1'b1;
          if (sec_done && (time_left != 7'd0)) time_nxt = time_left - 7'd1;
        end
        if (nxt_state == ST_DYING) begin
          lives_nxt = lives_dec_sat(lives);
          death_nxt = '0;
        end
      end
      ST_DYING: begin
        if (frame_tick && !death_done) death_nxt = death_cnt + 1'b1;
        if (nxt_state == ST_PLAY) respawn_nxt = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lives     <= LIVES_INIT;
      time_left <= TIME_INIT;
      frame_cnt <= '0;
      death_cnt <= '0;
      respawn   <= 1'b0;
    end else begin
      lives     <= lives_nxt;
      time_left <= time_nxt;
      frame_cnt <= frame_nxt;
      death_cnt <= death_nxt;
      respawn   <= respawn_nxt;
    end
  end

  assign state = cur_state;

endmodule
`default_nettype wire

// File: tb/tb_game_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_game_ctrl
// Purpose  : Self-checking bench for game_ctrl: directed sequences, a vector
//            table and randomized stimulus against a behavioural model.
// Revision : 1.0  initial release
// ============================================================================
module tb_game_ctrl;

  localparam int N  = 4;   // debounce cycles
  localparam int SL = 2;   // start lives
  localparam int TL = 3;   // time limit
  localparam int F  = 4;   // frames per second
  localparam int D  = 2;   // death frames

  localparam int S_MENU = 0, S_PLAY = 1, S_LOSE = 2, S_WIN = 3, S_DYING = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start_n = 1'b1;
  logic       frame_tick = 1'b0;
  logic       in_lava = 1'b0;
  logic       at_goal = 1'b0;
  logic       force_lose = 1'b0;
  logic       force_win = 1'b0;
  logic [2:0] state;
  logic [1:0] lives;
  logic [6:0] time_left;
  logic       respawn;

  game_ctrl #(
    .DEBOUNCE_CYCLES(N),
    .START_LIVES    (SL),
    .TIME_LIMIT_S   (TL),
    .FRAMES_PER_SEC (F),
    .DEATH_FRAMES   (D)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start_n   (start_n),
    .frame_tick(frame_tick),
    .in_lava   (in_lava),
    .at_goal   (at_goal),
    .force_lose(force_lose),
    .force_win (force_win),
    .state     (state),
    .lives     (lives),
    .time_left (time_left),
    .respawn   (respawn)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int resp_seen = 0;

  // ---------------- behavioural reference model ----------------
  int m_state, m_lives, m_time, m_fticks, m_dticks, m_resp, m_level, m_press;
  bit raw[$];    // {sample two flops back, sample one flop back}
  bit seen[$];   // last N synchronised samples

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = S_MENU; m_lives = SL; m_time = TL; m_fticks = 0; m_dticks = 0;
    m_resp = 0; m_level = 1; m_press = 0;
    raw = '{1'b1, 1'b1};
    seen = {};
  endtask

  task automatic reload();
    m_state = S_PLAY; m_lives = SL; m_time = TL; m_fticks = 0; m_resp = 1;
  endtask

  task automatic model_edge();
    int p;
    bit s;
    bit all_diff;
    bit expire;
    if (rst) begin
      model_reset();
      return;
    end
    p = m_press;
    // key: level accepted after N consecutive synchronised samples disagree
    s = raw[0];
    seen.push_back(s);
    if (seen.size() > N) void'(seen.pop_front());
    m_press = 0;
    if (seen.size() == N) begin
      all_diff = 1'b1;
      foreach (seen[i]) if (int'(seen[i]) == m_level) all_diff = 1'b0;
      if (all_diff) begin
        m_press = (m_level == 1) ? 1 : 0;
        m_level = int'(s);
      end
    end
    raw.push_back(start_n);
    void'(raw.pop_front());
    // game flow, using the press decided on the previous edge
    m_resp = 0;
    case (m_state)
      S_MENU: if (p != 0) reload();
      S_LOSE: if (p != 0) reload();
      S_WIN:  if (p != 0) m_state = S_MENU;
      S_PLAY: begin
        expire = 1'b0;
        if (frame_tick) begin
          m_fticks++;
          if (m_fticks == F) begin
            m_fticks = 0;
            if (m_time > 0) m_time--;
            if (m_time == 0) expire = 1'b1;
          end
        end
        if (force_lose || expire) m_state = S_LOSE;
        else if (in_lava) begin
          m_state = S_DYING;
          if (m_lives > 0) m_lives--;
          m_dticks = 0;
        end else if (at_goal || force_win) m_state = S_WIN;
      end
      S_DYING: begin
        if (frame_tick) begin
          m_dticks++;
          if (m_dticks == D) begin
            if (m_lives == 0) m_state = S_LOSE;
            else begin m_state = S_PLAY; m_resp = 1; end
          end
        end
      end
      default: ;
    endcase
  endtask

  // One clock: model steps with the inputs present at the edge, DUT is
  // sampled 1 ns later.
  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    check("state", int'(state), m_state);
    check("lives", int'(lives), m_lives);
    check("time_left", int'(time_left), m_time);
    check("respawn", int'(respawn), m_resp);
    if (respawn) resp_seen++;
  endtask

  task automatic set_in(input bit ft, input bit lv, input bit gl, input bit fl, input bit fw);
    frame_tick = ft; in_lava = lv; at_goal = gl; force_lose = fl; force_win = fw;
  endtask

  task automatic press_key();
    set_in(0, 0, 0, 0, 0);
    start_n = 1'b0;
    repeat (10) cycle();
    start_n = 1'b1;
    repeat (10) cycle();
  endtask

  typedef struct {
    bit ft, lava, goal, flose, fwin;
    int e_state, e_lives, e_time, e_resp;
  } vec_t;

  vec_t tbl[10];

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int seg_left;
    tbl[0] = '{0, 1, 0, 0, 0, S_DYING, 1, 3, 0};
    tbl[1] = '{1, 1, 0, 0, 0, S_DYING, 1, 3, 0};
    tbl[2] = '{0, 0, 1, 0, 0, S_DYING, 1, 3, 0};
    tbl[3] = '{1, 0, 0, 0, 0, S_PLAY,  1, 3, 1};
    tbl[4] = '{0, 0, 0, 0, 0, S_PLAY,  1, 3, 0};
    tbl[5] = '{1, 0, 0, 0, 0, S_PLAY,  1, 3, 0};
    tbl[6] = '{0, 1, 1, 0, 0, S_DYING, 0, 3, 0};
    tbl[7] = '{1, 0, 0, 0, 0, S_DYING, 0, 3, 0};
    tbl[8] = '{1, 0, 0, 0, 0, S_LOSE,  0, 3, 0};
    tbl[9] = '{1, 1, 1, 0, 0, S_LOSE,  0, 3, 0};

    model_reset();
    rst = 1'b1;
    repeat (2) cycle();
    check("rst_state", int'(state), S_MENU);
    check("rst_lives", int'(lives), SL);
    check("rst_time", int'(time_left), TL);
    check("rst_respawn", int'(respawn), 0);
    rst = 1'b0;

    // bouncing key never settles for N cycles
    resp_seen = 0;
    for (int i = 0; i < 20; i++) begin
      start_n = ((i / 2) % 2) != 0;
      cycle();
    end
    start_n = 1'b1;
    repeat (10) cycle();
    check("bounce_state", int'(state), S_MENU);
    check("bounce_respawn_count", resp_seen, 0);

    // clean press from menu
    resp_seen = 0;
    press_key();
    check("start_state", int'(state), S_PLAY);
    check("start_lives", int'(lives), SL);
    check("start_time", int'(time_left), TL);
    check("start_respawn_count", resp_seen, 1);

    // lava / death / respawn table
    for (int i = 0; i < 10; i++) begin
      set_in(tbl[i].ft, tbl[i].lava, tbl[i].goal, tbl[i].flose, tbl[i].fwin);
      cycle();
      check($sformatf("tbl%0d_state", i), int'(state), tbl[i].e_state);
      check($sformatf("tbl%0d_lives", i), int'(lives), tbl[i].e_lives);
      check($sformatf("tbl%0d_time", i), int'(time_left), tbl[i].e_time);
      check($sformatf("tbl%0d_respawn", i), int'(respawn), tbl[i].e_resp);
    end

    // restart from lose, then force_lose beats lava
    resp_seen = 0;
    press_key();
    check("relaunch_state", int'(state), S_PLAY);
    check("relaunch_lives", int'(lives), SL);
    check("relaunch_respawn_count", resp_seen, 1);
    set_in(0, 1, 0, 1, 0);
    cycle();
    check("forcelose_state", int'(state), S_LOSE);
    check("forcelose_lives", int'(lives), SL);

    // timer runs out after TL*F ticks
    press_key();
    for (int i = 1; i <= TL * F; i++) begin
      set_in(1, 0, 0, 0, 0);
      cycle();
      check($sformatf("timer%0d_time", i), int'(time_left), TL - i / F);
      check($sformatf("timer%0d_state", i), int'(state), (i == TL * F) ? S_LOSE : S_PLAY);
      set_in(0, 0, 0, 0, 0);
      cycle();
    end

    // goal -> win -> menu
    press_key();
    set_in(0, 0, 1, 0, 0);
    cycle();
    check("goal_state", int'(state), S_WIN);
    press_key();
    check("win_to_menu_state", int'(state), S_MENU);

    // reset during dying
    press_key();
    set_in(0, 1, 0, 0, 0);
    cycle();
    check("dying_state", int'(state), S_DYING);
    check("dying_lives", int'(lives), SL - 1);
    set_in(0, 0, 0, 0, 0);
    rst = 1'b1;
    cycle();
    check("rst_dying_state", int'(state), S_MENU);
    check("rst_dying_lives", int'(lives), SL);
    check("rst_dying_time", int'(time_left), TL);
    rst = 1'b0;

    // reset in the middle of a debounce must not produce a press
    start_n = 1'b0;
    repeat (5) cycle();
    rst = 1'b1;
    start_n = 1'b1;
    cycle();
    rst = 1'b0;
    repeat (15) cycle();
    check("rst_debounce_state", int'(state), S_MENU);

    // randomized run
    seg_left = 0;
    for (int i = 0; i < 3000; i++) begin
      if (seg_left == 0) begin
        start_n  = ($urandom_range(0, 1) != 0);
        seg_left = $urandom_range(1, 12);
      end
      seg_left--;
      set_in($urandom_range(0, 2) == 0, $urandom_range(0, 11) == 0,
             $urandom_range(0, 24) == 0, $urandom_range(0, 59) == 0,
             $urandom_range(0, 59) == 0);
      rst = ($urandom_range(0, 399) == 0);
      cycle();
    end
    rst = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/game_ctrl.md
GAME_CTRL -- requirements
Module: game_ctrl

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 1000000, the number of stable clk cycles before the start key level is accepted.
REQ-002 SHALL have parameter START_LIVES, default 3, the lives loaded at game start (range 1..3).
REQ-003 SHALL have parameter TIME_LIMIT_S, default 60, the round time in seconds (range 1..99).
REQ-004 SHALL have parameter FRAMES_PER_SEC, default 60, the frame_tick pulses per second.
REQ-005 SHALL have parameter DEATH_FRAMES, default 30, the frame_tick pulses spent in DYING.
REQ-006 SHALL have port clk, input, 1, the 25 MHz VGA pixel clock; the block uses one clock.
REQ-007 SHALL have port rst, input, 1; reset is synchronous and active-high.
REQ-008 SHALL have port start_n, input, 1, the raw active-low start key (asynchronous).
REQ-009 SHALL have port frame_tick, input, 1, a one-cycle pulse once per frame.
REQ-010 SHALL have port in_lava, input, 1, the character-overlaps-lava level.
REQ-011 SHALL have port at_goal, input, 1, the character-reached-goal level.
REQ-012 SHALL have ports force_lose and force_win, input, 1 each, debug switch levels.
REQ-013 SHALL have port state, output, 3, the game state code consumed by the renderer.
REQ-014 SHALL have port lives, output, 2, the remaining lives.
REQ-015 SHALL have port time_left, output, 7, the remaining seconds in binary.
REQ-016 SHALL have port respawn, output, 1, a one-cycle pulse that tells the character block to return to its spawn point.

Function
REQ-017 SHALL synchronise start_n through 2 flops before any use.
REQ-018 SHALL accept a new debounced key level only after the synchronised level differs from the current debounced level for DEBOUNCE_CYCLES consecutive cycles; any bounce restarts the count.
REQ-019 SHALL generate start_press, a one-cycle pulse, on the debounced 1->0 transition only.
REQ-020 SHALL encode the states as MENU=000, PLAY=001, LOSE=010, WIN=011 and DYING=100.
REQ-021 SHALL move MENU->PLAY on start_press, loading lives=START_LIVES, time_left=TIME_LIMIT_S and frame_cnt=0, and pulsing respawn in the same cycle as the transition.
REQ-022 SHALL evaluate PLAY exits with priority force_lose or timer expiry (->LOSE), then in_lava (->DYING), then at_goal or force_win (->WIN).
REQ-023 SHALL, in PLAY, increment frame_cnt on each frame_tick; at frame_cnt==FRAMES_PER_SEC-1 with frame_tick, it SHALL clear frame_cnt and decrement time_left.
REQ-024 SHALL go to LOSE when a decrement makes time_left 0; time_left SHALL never underflow below 0.
REQ-025 SHALL decrement lives once on entry to DYING, saturating at 0, and clear death_cnt.
REQ-026 SHALL freeze the timer in DYING and count death_cnt on frame_tick.
REQ-027 SHALL leave DYING after DEATH_FRAMES ticks: to LOSE if lives==0, else to PLAY with a respawn pulse, with time_left kept.
REQ-028 SHALL move LOSE->PLAY on start_press with a full reload as in REQ-021.
REQ-029 SHALL move WIN->MENU on start_press.
REQ-030 SHALL ignore start_press in PLAY and DYING.
REQ-031 SHALL ignore in_lava and at_goal outside PLAY.
REQ-032 SHALL drive respawn high for exactly 1 cycle per event and otherwise low.
REQ-033 SHALL register all outputs, with a 1-cycle latency from the triggering input or tick.

Reset
REQ-034 SHALL set, on rst=1 at a clk edge, state=MENU, lives=START_LIVES, time_left=TIME_LIMIT_S, respawn=0, frame_cnt=0, death_cnt=0, debounced level=1 and debounce count=0.
REQ-035 SHALL honour reset mid-game or mid-debounce in the same edge and emit no start_press from it.

Structure
REQ-036 SHALL place the state codes (MENU, PLAY, LOSE, WIN, DYING) in shared package game_pkg, shared with the renderer and character blocks.
REQ-037 SHALL implement synchroniser, debounce and edge detect as sub-module key_debounce (params DEBOUNCE_CYCLES; ports clk, rst, key_n, level, press).

Verification (bench uses DEBOUNCE_CYCLES=4, FRAMES_PER_SEC=4, DEATH_FRAMES=2, TIME_LIMIT_S=3, START_LIVES=2)
REQ-038 Reset then start_n low for 10 cycles -> one start_press; state 000->001, lives=2, time_left=3, one respawn pulse.
REQ-039 start_n bouncing 0/1 every 2 cycles for 20 cycles, then released -> no state change, state stays 000.
REQ-040 In PLAY, issue 12 frame_ticks with no hazards -> time_left steps 3,2,1,0 and state=010 on the cycle after the 12th tick.
REQ-041 In PLAY, in_lava=1 -> DYING with lives=1; after 2 ticks -> PLAY with a respawn pulse; in_lava again -> DYING with lives=0; after 2 ticks -> LOSE.
REQ-042 In PLAY, assert in_lava and at_goal in the same cycle -> DYING, not WIN; force_lose with in_lava -> LOSE.
REQ-043 In PLAY, at_goal -> WIN; start_press -> MENU; rst asserted during DYING -> MENU with lives=2 on the next edge.
